// File: rtl/link_test_pkg.sv
// link_test_pkg
//   Shared definitions for the parallel-link self-test controller:
//   controller state encoding, data pattern encodings and the pattern
//   step function used by both the transmit and expected-word generators.
package link_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LAUNCH  = 3'd1,
      ST_WAIT_TX = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_PASS    = 3'd4,
      ST_FAIL    = 3'd5
   } state_t;

   localparam int PAT_DEC   = 0;  // decrement, starting from all-ones
   localparam int PAT_INC   = 1;  // increment, starting from 1
   localparam int PAT_WALK1 = 2;  // walking one, starting at bit 0

   // Pattern arithmetic is done on a wide word and masked down to the
   // link width, so one function serves every DATA_W up to MAX_W.
   localparam int MAX_W = 64;
   typedef logic [MAX_W-1:0] word_t;

   function automatic word_t width_mask(input int w);
      word_t m;
      m = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic word_t first_word(input int w, input int pat);
      word_t r;
      if (pat == PAT_DEC) r = width_mask(w);
      else                r = word_t'(1);
      return r;
   endfunction

   // Next word modulo 2^w: decrement wraps 0 -> all-ones, increment wraps
   // all-ones -> 0, walking one rotates left with the MSB entering bit 0.
   function automatic word_t next_word(input word_t cur, input int w, input int pat);
      word_t r;
      logic  msb;
      msb = 1'b0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i == w - 1) msb = cur[i];
      end
      case (pat)
         PAT_INC:   r = cur + word_t'(1);
         PAT_WALK1: r = (cur << 1) | word_t'(msb);
         default:   r = cur - word_t'(1);
      endcase
      return r & width_mask(w);
   endfunction

endpackage

// File: rtl/link_test_ctrl_if.sv
// link_test_ctrl_if
//   Word-level connection between the test controller and the
//   sender/receiver pair.
//   tx_start : 1-cycle pulse from the controller, launches tx_data
//   tx_data  : word to send, held stable from tx_start until tx_done
//   tx_done  : 1-cycle pulse from the sender, current word delivered
//   rx_valid : 1-cycle pulse from the receiver, rx_data holds a new word
//   rx_data  : received word
//
//   Handshake: there is no back-pressure. A word is transferred on every
//   cycle in which its pulse is high; the controller issues the next
//   tx_start only after tx_done and never in the same cycle, and it must
//   accept rx_valid on any cycle.
interface link_test_ctrl_if #(
   parameter int DATA_W = 32
);
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic              tx_done;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;

   modport master (
      output tx_start, tx_data,
      input  tx_done, rx_valid, rx_data
   );

   modport slave (
      input  tx_start, tx_data,
      output tx_done, rx_valid, rx_data
   );
endinterface

// File: rtl/link_pattern_gen.sv
// link_pattern_gen
//   One step-on-demand pattern source. Used twice by the controller
//   (transmit stream and expected stream) so both follow the same
//   sequence by construction.
//   clk, rst : clock, asynchronous active-high reset
//   load     : return to the first word of the pattern (wins over advance)
//   advance  : step to the next word
//   word     : current word
module link_pattern_gen
   import link_test_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PATTERN = PAT_DEC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              advance,
   output logic [DATA_W-1:0] word
);

   localparam logic [DATA_W-1:0] FIRST_W = DATA_W'(first_word(DATA_W, PATTERN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word <= FIRST_W;
      end else if (load) begin
         word <= FIRST_W;
      end else if (advance) begin
         word <= DATA_W'(next_word(word_t'(word), DATA_W, PATTERN));
      end
   end

endmodule

// File: rtl/link_test_ctrl.sv
// link_test_ctrl
//   Self-checking test controller for the FPGA-to-FPGA parallel link.
//   On a rising edge of en it sends WORD_COUNT pattern words through the
//   sender, checks every word coming back from the receiver against an
//   independently generated expected stream, and reports the verdict.
//   clk, rst     : system clock, asynchronous active-high reset
//   link         : sender/receiver word interface (master side)
//   en           : test enable, rising edge starts a run, low aborts one
//   busy         : run in progress (LAUNCH / WAIT_TX / DRAIN)
//   led_pass     : last run completed with no errors
//   led_fail     : last run completed with error, timeout or overrun
//   sent_count   : words acknowledged by the sender this run
//   recv_count   : words received this run
//   err_count    : mismatching words, saturating
//   timeout_flag : run failed by the watchdog
//   overrun_flag : a word arrived after WORD_COUNT words were received
//   dbg_state    : current controller state
module link_test_ctrl
   import link_test_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int WORD_COUNT     = 100,
   parameter int PATTERN        = 0,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = $clog2(WORD_COUNT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   link_test_ctrl_if.master  link,
   input  logic              en,
   output logic              busy,
   output logic              led_pass,
   output logic              led_fail,
   output logic [CNT_W-1:0]  sent_count,
   output logic [CNT_W-1:0]  recv_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              timeout_flag,
   output logic              overrun_flag,
   output state_t            dbg_state
);

   localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] WC      = CNT_W'(WORD_COUNT);
   localparam logic [CNT_W-1:0] WC_M1   = CNT_W'(WORD_COUNT - 1);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_next;
   logic              en_q, en_q2;
   logic              en_rise;
   logic              active;
   logic              abort;
   logic              start;
   logic              tx_ack;
   logic              rx_take;
   logic              rx_over;
   logic              rx_bad;
   logic              wd_run;
   logic              wd_expire;
   logic              timeout_hit;
   logic              drain_bad;
   logic [WD_W-1:0]   wd_cnt;
   logic [DATA_W-1:0] tx_word;
   logic [DATA_W-1:0] exp_word;

   // en passes through one register; the edge is taken between that
   // register and its delayed copy, giving launch two cycles after the pin.
   assign en_rise = en_q & ~en_q2;
   assign active  = (state == ST_LAUNCH) || (state == ST_WAIT_TX) || (state == ST_DRAIN);
   assign abort   = active & ~en_q;
   assign start   = ~active & en_rise;

   assign tx_ack  = (state == ST_WAIT_TX) & link.tx_done;
   // Words beyond WORD_COUNT are not checked or counted, only flagged.
   assign rx_take = active & link.rx_valid & (recv_count != WC);
   assign rx_over = active & link.rx_valid & (recv_count == WC);
   assign rx_bad  = rx_take & (link.rx_data != exp_word);

   assign wd_run    = ((state == ST_WAIT_TX) || (state == ST_DRAIN))
                      & ~link.tx_done & ~link.rx_valid;
   assign wd_expire = wd_run & (wd_cnt == WD_LAST);

   // An overrun landing in the very cycle DRAIN decides must still fail.
   assign drain_bad = (err_count != '0) | overrun_flag | rx_over;

   always_comb begin
      state_next  = state;
      timeout_hit = 1'b0;
      unique case (state)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (en_rise) state_next = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            state_next = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (wd_expire) begin
               state_next  = ST_FAIL;
               timeout_hit = 1'b1;
            end else if (tx_ack) begin
               state_next = (sent_count == WC_M1) ? ST_DRAIN : ST_LAUNCH;
            end
         end
         ST_DRAIN: begin
            if (recv_count == WC) begin
               state_next = drain_bad ? ST_FAIL : ST_PASS;
            end else if (wd_expire) begin
               state_next  = ST_FAIL;
               timeout_hit = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      if (abort) begin
         state_next  = ST_IDLE;
         timeout_hit = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         en_q         <= 1'b0;
         en_q2        <= 1'b0;
         sent_count   <= '0;
         recv_count   <= '0;
         err_count    <= '0;
         timeout_flag <= 1'b0;
         overrun_flag <= 1'b0;
         wd_cnt       <= '0;
      end else begin
         state <= state_next;
         en_q  <= en;
         en_q2 <= en_q;

         if (start) begin
            sent_count   <= '0;
            recv_count   <= '0;
            err_count    <= '0;
            timeout_flag <= 1'b0;
            overrun_flag <= 1'b0;
         end else begin
            if (tx_ack)                     sent_count   <= sent_count + CNT_W'(1);
            if (rx_take)                    recv_count   <= recv_count + CNT_W'(1);
            if (rx_bad && (err_count != '1)) err_count   <= err_count + CNT_W'(1);
            if (rx_over)                    overrun_flag <= 1'b1;
            if (timeout_hit)                timeout_flag <= 1'b1;
         end

         if ((state_next == ST_LAUNCH) || link.tx_done || link.rx_valid) begin
            wd_cnt <= '0;
         end else if (wd_run) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
      end
   end

   link_pattern_gen #(
      .DATA_W  (DATA_W),
      .PATTERN (PATTERN)
   ) u_tx_gen (
      .clk     (clk),
      .rst     (rst),
      .load    (start),
      .advance (tx_ack),
      .word    (tx_word)
   );

   link_pattern_gen #(
      .DATA_W  (DATA_W),
      .PATTERN (PATTERN)
   ) u_exp_gen (
      .clk     (clk),
      .rst     (rst),
      .load    (start),
      .advance (rx_take),
      .word    (exp_word)
   );

   assign link.tx_start = (state == ST_LAUNCH);
   assign link.tx_data  = tx_word;
   assign busy          = active;
   assign led_pass      = (state == ST_PASS);
   assign led_fail      = (state == ST_FAIL);
   assign dbg_state     = state;

endmodule

// File: tb/tb_link_test_ctrl.sv
// tb_link_test_ctrl
//   Directed bench for link_test_ctrl. Instance A: DATA_W=8, WORD_COUNT=4,
//   decrement pattern, TIMEOUT_CYCLES=16. Instance B: DATA_W=8,
//   WORD_COUNT=10, walking-one pattern. Both share the sender/receiver
//   pulse inputs; the idle instance ignores them.
module tb_link_test_ctrl;
   import link_test_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "bench time limit");
   end

   // ---------------- DUT wiring ----------------
   logic       en_a, en_b;
   logic       tx_done, rx_valid;
   logic [7:0] rx_data;
   logic       sel_b;

   link_test_ctrl_if #(.DATA_W(8)) link_a ();
   link_test_ctrl_if #(.DATA_W(8)) link_b ();

   assign link_a.tx_done  = tx_done;
   assign link_a.rx_valid = rx_valid;
   assign link_a.rx_data  = rx_data;
   assign link_b.tx_done  = tx_done;
   assign link_b.rx_valid = rx_valid;
   assign link_b.rx_data  = rx_data;

   logic       busy_a, pass_a, fail_a, tmo_a, ovr_a;
   logic [2:0] sent_a, recv_a, err_a;
   state_t     st_a;
   logic       busy_b, pass_b, fail_b, tmo_b, ovr_b;
   logic [3:0] sent_b, recv_b, err_b;
   state_t     st_b;

   link_test_ctrl #(
      .DATA_W(8), .WORD_COUNT(4), .PATTERN(0), .TIMEOUT_CYCLES(16)
   ) dut_a (
      .clk(clk), .rst(rst), .link(link_a), .en(en_a),
      .busy(busy_a), .led_pass(pass_a), .led_fail(fail_a),
      .sent_count(sent_a), .recv_count(recv_a), .err_count(err_a),
      .timeout_flag(tmo_a), .overrun_flag(ovr_a), .dbg_state(st_a)
   );

   link_test_ctrl #(
      .DATA_W(8), .WORD_COUNT(10), .PATTERN(2), .TIMEOUT_CYCLES(16)
   ) dut_b (
      .clk(clk), .rst(rst), .link(link_b), .en(en_b),
      .busy(busy_b), .led_pass(pass_b), .led_fail(fail_b),
      .sent_count(sent_b), .recv_count(recv_b), .err_count(err_b),
      .timeout_flag(tmo_b), .overrun_flag(ovr_b), .dbg_state(st_b)
   );

   logic       obs_start;
   logic [7:0] obs_data;
   assign obs_start = sel_b ? link_b.tx_start : link_a.tx_start;
   assign obs_data  = sel_b ? link_b.tx_data  : link_a.tx_data;

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_en(input logic v);
      if (sel_b) en_b = v;
      else       en_a = v;
   endtask

   // Ends in the LAUNCH cycle of the first word.
   task automatic start_run();
      set_en(1'b0);
      tick();
      tick();
      set_en(1'b1);
      tick();
      check("start_latency_1", 32'(obs_start), 32'd0);
      tick();
      check("start_latency_2", 32'(obs_start), 32'd1);
   endtask

   // Sender/receiver model for one word.
   // mode 0: receive, then tx_done; mode 1: both in one cycle;
   // mode 2: like 0 with bit 0 of the received word flipped.
   task automatic xfer(input int mode);
      int         n;
      logic [7:0] exp_w;
      n = 0;
      while (!obs_start && n < 20) begin
         tick();
         n++;
      end
      if (!obs_start) begin
         check("tx_start_wait", 32'(obs_start), 32'd1);
         return;
      end
      if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      else                  exp_w = 'x;
      check("tx_data", 32'(obs_data), 32'(exp_w));
      tick();
      check("tx_start_pulse", 32'(obs_start), 32'd0);
      if (mode == 1) begin
         tx_done  = 1'b1;
         rx_valid = 1'b1;
         rx_data  = exp_w;
         tick();
         tx_done  = 1'b0;
         rx_valid = 1'b0;
      end else begin
         rx_valid = 1'b1;
         rx_data  = (mode == 2) ? (exp_w ^ 8'h01) : exp_w;
         tick();
         rx_valid = 1'b0;
         check("tx_data_hold", 32'(obs_data), 32'(exp_w));
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end
   endtask

   logic [7:0] walk_tab [10];

   // ---------------- directed sequence ----------------
   initial begin
      walk_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
      rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
      tx_done = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; sel_b = 1'b0;
      tick();
      tick();

      // reset state
      check("rst_busy",     32'(busy_a), 32'd0);
      check("rst_pass",     32'(pass_a), 32'd0);
      check("rst_fail",     32'(fail_a), 32'd0);
      check("rst_sent",     32'(sent_a), 32'd0);
      check("rst_recv",     32'(recv_a), 32'd0);
      check("rst_err",      32'(err_a),  32'd0);
      check("rst_timeout",  32'(tmo_a),  32'd0);
      check("rst_overrun",  32'(ovr_a),  32'd0);
      check("rst_tx_start", 32'(link_a.tx_start), 32'd0);
      check("rst_tx_data_a", 32'(link_a.tx_data), 32'hFF);
      check("rst_tx_data_b", 32'(link_b.tx_data), 32'h01);
      rst = 1'b0;
      tick();

      // walking one over 10 words, wrapping after bit 7
      sel_b = 1'b1;
      for (int i = 0; i < 10; i++) exp_q.push_back(walk_tab[i]);
      start_run();
      for (int i = 0; i < 10; i++) xfer(0);
      tick();
      check("walk_pass", 32'(pass_b), 32'd1);
      check("walk_sent", 32'(sent_b), 32'd10);
      check("walk_recv", 32'(recv_b), 32'd10);
      check("walk_err",  32'(err_b),  32'd0);
      sel_b = 1'b0;

      // clean decrement run
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
      exp_q.push_back(8'hFD); exp_q.push_back(8'hFC);
      start_run();
      for (int i = 0; i < 4; i++) xfer(0);
      check("dec_drain_busy", 32'(busy_a), 32'd1);
      tick();
      check("dec_pass", 32'(pass_a), 32'd1);
      check("dec_fail", 32'(fail_a), 32'd0);
      check("dec_busy", 32'(busy_a), 32'd0);
      check("dec_sent", 32'(sent_a), 32'd4);
      check("dec_recv", 32'(recv_a), 32'd4);
      check("dec_err",  32'(err_a),  32'd0);

      // third received word corrupted
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
      exp_q.push_back(8'hFD); exp_q.push_back(8'hFC);
      start_run();
      check("restart_clears_led", 32'(pass_a), 32'd0);
      xfer(0); xfer(0); xfer(2); xfer(0);
      tick();
      check("corrupt_err",  32'(err_a),  32'd1);
      check("corrupt_fail", 32'(fail_a), 32'd1);
      check("corrupt_pass", 32'(pass_a), 32'd0);
      check("corrupt_recv", 32'(recv_a), 32'd4);

      // sender never answers: FAIL 16 cycles after entering WAIT_TX
      start_run();
      repeat (16) tick();
      check("tmo_not_yet", 32'(fail_a), 32'd0);
      check("tmo_busy",    32'(busy_a), 32'd1);
      tick();
      check("tmo_fail", 32'(fail_a), 32'd1);
      check("tmo_flag", 32'(tmo_a),  32'd1);
      check("tmo_sent", 32'(sent_a), 32'd0);

      // simultaneous tx_done/rx_valid on the last word, then an extra word in DRAIN
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
      exp_q.push_back(8'hFD); exp_q.push_back(8'hFC);
      start_run();
      check("tmo_flag_cleared", 32'(tmo_a), 32'd0);
      xfer(0); xfer(0); xfer(0);
      check("sim_sent_before", 32'(sent_a), 32'd3);
      check("sim_recv_before", 32'(recv_a), 32'd3);
      xfer(1);
      check("sim_sent_after", 32'(sent_a), 32'd4);
      check("sim_recv_after", 32'(recv_a), 32'd4);
      rx_valid = 1'b1;
      rx_data  = 8'hFC;
      tick();
      rx_valid = 1'b0;
      check("ovr_flag", 32'(ovr_a),  32'd1);
      check("ovr_fail", 32'(fail_a), 32'd1);
      check("ovr_pass", 32'(pass_a), 32'd0);

      // en dropped after two words
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
      start_run();
      xfer(0); xfer(0);
      en_a = 1'b0;
      tick();
      tick();
      check("abort_busy",  32'(busy_a), 32'd0);
      check("abort_state", 32'(st_a),   32'(ST_IDLE));
      check("abort_sent",  32'(sent_a), 32'd2);
      check("abort_recv",  32'(recv_a), 32'd2);
      check("abort_pass",  32'(pass_a), 32'd0);
      check("abort_fail",  32'(fail_a), 32'd0);

      // re-raise en: counters cleared, pattern restarts at FF
      exp_q.push_back(8'hFF);
      start_run();
      check("rerun_sent", 32'(sent_a), 32'd0);
      check("rerun_recv", 32'(recv_a), 32'd0);
      xfer(0);
      check("rerun_sent1", 32'(sent_a), 32'd1);
      check("rerun_tx_data2", 32'(link_a.tx_data), 32'hFE);

      // asynchronous reset mid-run
      #2 rst = 1'b1;
      #1;
      check("arst_busy",     32'(busy_a), 32'd0);
      check("arst_sent",     32'(sent_a), 32'd0);
      check("arst_recv",     32'(recv_a), 32'd0);
      check("arst_tx_start", 32'(link_a.tx_start), 32'd0);
      check("arst_tx_data",  32'(link_a.tx_data), 32'hFF);
      tick();
      rst = 1'b0;
      tick();

      // final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
